// File: rtl/rc_pwm_generator.sv
`default_nettype none
// ============================================================================
// Module      : rc_pwm_generator
// Description : RC servo PWM encoder. Turns an 8-bit command into a fixed-period
//               frame with a clamped high pulse. Commands are double-buffered.
// Revision    : 1.0 - initial release
// ============================================================================
module rc_pwm_generator #(
   parameter int FRAME_PERIOD  = 20000,
   parameter int MIN_PULSE     = 1000,
   parameter int MAX_PULSE     = 2000,
   parameter int STEP          = 4,
   parameter int NEUTRAL_PULSE = 1500
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       enable_i,
   input  logic [7:0] value_i,
   input  logic       value_valid_i,
   output logic       value_ready_o,
   output logic       pwm_o,
   output logic       frame_start_o
);

   localparam int c_CNT_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_PULSE = 2'd1;
   localparam logic [1:0] c_GAP   = 2'd2;

   localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(FRAME_PERIOD - 1);
   localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_NEUTRAL = c_CNT_W'(NEUTRAL_PULSE);
   localparam logic [c_CNT_W-1:0] c_MAXW    = c_CNT_W'(MAX_PULSE);

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_cnt_nxt;
   logic               w_frame_entry;

   logic [c_CNT_W-1:0] r_width;
   logic [c_CNT_W-1:0] r_shadow;
   logic               r_shadow_full;
   logic               w_accept;
   logic [31:0]        w_raw;
   logic [c_CNT_W-1:0] w_width_cmd;

   logic               r_pwm;
   logic               r_frame_start;
   logic               w_pwm_nxt;
   logic               w_frame_start_nxt;

   // Width arithmetic done at 32 bits so the clamp sees the true product
   always_comb begin
      w_raw       = 32'(MIN_PULSE) + 32'(value_i) * 32'(STEP);
      w_width_cmd = (w_raw > 32'(MAX_PULSE)) ? c_MAXW : c_CNT_W'(w_raw);
   end

   assign w_accept      = value_valid_i && !r_shadow_full;
   assign value_ready_o = !r_shadow_full;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_state <= c_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // The counter runs 0..FRAME_PERIOD-1 across both PULSE and GAP
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_frame_entry = 1'b0;
      case (r_state)
         c_IDLE: begin
            w_cnt_nxt = '0;
            if (enable_i) begin
               w_state_nxt   = c_PULSE;
               w_frame_entry = 1'b1;
            end
         end
         c_PULSE: begin
            w_cnt_nxt = r_cnt + c_ONE;
            if (r_cnt == r_width - c_ONE) begin
               w_state_nxt = c_GAP;
            end
         end
         c_GAP: begin
            if (r_cnt == c_LAST) begin
               w_cnt_nxt = '0;
               if (enable_i) begin
                  w_state_nxt   = c_PULSE;
                  w_frame_entry = 1'b1;
               end else begin
                  w_state_nxt = c_IDLE;
               end
            end else begin
               w_cnt_nxt = r_cnt + c_ONE;
            end
         end
         default: begin
            w_state_nxt = c_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      w_pwm_nxt         = (w_state_nxt == c_PULSE);
      w_frame_start_nxt = w_frame_entry;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_pwm         <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_pwm         <= w_pwm_nxt;
         r_frame_start <= w_frame_start_nxt;
      end
   end

   // A full shadow is never accepting, so load and accept cannot collide
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_width       <= c_NEUTRAL;
         r_shadow      <= '0;
         r_shadow_full <= 1'b0;
      end else if (w_frame_entry && r_shadow_full) begin
         r_width       <= r_shadow;
         r_shadow_full <= 1'b0;
      end else if (w_accept) begin
         r_shadow      <= w_width_cmd;
         r_shadow_full <= 1'b1;
      end
   end

   assign pwm_o         = r_pwm;
   assign frame_start_o = r_frame_start;

endmodule
`default_nettype wire
